// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time, buffers the
// returned word for the decode register and squashes it on execute redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic        valid_q, valid_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  assign target   = PCTargetE & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ibuf_d     = ibuf_q;
    valid_d    = valid_q;

    if (PCSrcE) begin
      pc_d    = target;
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = PCSrcE ? target : pc_q;
      end

      FETCH: begin
        if (PCSrcE) begin
          if (imem_ack) begin
            req_addr_d = target;
            state_d    = FETCH;
          end else begin
            state_d    = DROP;
          end
        end else if (imem_ack) begin
          ibuf_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = READY;
        end
      end

      READY: begin
        if (PCSrcE) begin
          req_addr_d = target;
          state_d    = FETCH;
        end else if (!StallF) begin
          pc_d       = pc_plus4;
          req_addr_d = pc_plus4;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end
      end

      DROP: begin
        // The outstanding request is still owed one ack; once it lands,
        // restart at the newest PC (a redirect on that same edge wins).
        if (imem_ack) begin
          req_addr_d = PCSrcE ? target : pc_q;
          state_d    = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ibuf_q     <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ibuf_q     <= ibuf_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = req_addr_q;
  assign instrF    = valid_q ? ibuf_q : NOP;
  assign validF    = valid_q;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, stalls,
// redirects with and without an outstanding request, PC wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP     (NOP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .instrF    (instrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .validF    (validF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (instrF !== NOP_W) begin errors++; $display("FAIL reset_instr: got %h expected %h", instrF, NOP_W); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h expected 00000000", PCF); end
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pcplus4: got %h expected 00000004", PCPlus4F); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", validF); end
    reset = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
  endtask

  // Zero-wait memory, StallF=0: words 0x0, 0x4, 0x8 each shown once then consumed.
  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'(i * 4);
      word     = 32'hA000_0000 + 32'(i);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin errors++; $display("FAIL seq_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, exp_addr); end
      checks++; if (validF !== 1'b0 || instrF !== NOP_W) begin errors++; $display("FAIL seq_bubble[%0d]: got valid=%b instr=%h expected valid=0 instr=%h", i, validF, instrF, NOP_W); end
      imem_ack = 1'b1; imem_rdata = word;
      step();
      imem_ack = 1'b0;
      checks++; if (validF !== 1'b1 || instrF !== word) begin errors++; $display("FAIL seq_instr[%0d]: got valid=%b instr=%h expected valid=1 instr=%h", i, validF, instrF, word); end
      checks++; if (PCF !== exp_addr || PCPlus4F !== exp_addr + 32'd4) begin errors++; $display("FAIL seq_pc[%0d]: got pc=%h pc4=%h expected pc=%h pc4=%h", i, PCF, PCPlus4F, exp_addr, exp_addr + 32'd4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_ready_req[%0d]: got %b expected 0", i, imem_req); end
      step();
    end
  endtask

  // Word at 0x10 held for three stalled cycles, then consumed exactly once.
  task automatic test_stall();
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_pre_addr: got %h expected 0000000c", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hA000_0003;
    step();
    imem_ack = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_addr: got req=%b addr=%h expected req=1 addr=00000010", imem_req, imem_addr); end
    StallF = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (validF !== 1'b1 || instrF !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_instr[%0d]: got valid=%b instr=%h expected valid=1 instr=deadbeef", c, validF, instrF); end
      checks++; if (PCF !== 32'h10 || PCPlus4F !== 32'h14) begin errors++; $display("FAIL stall_pc[%0d]: got pc=%h pc4=%h expected pc=00000010 pc4=00000014", c, PCF, PCPlus4F); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", c, imem_req); end
      step();
    end
    StallF = 1'b0;
    step();
    checks++; if (validF !== 1'b0 || imem_addr !== 32'h14 || PCF !== 32'h14) begin errors++; $display("FAIL stall_consume: got valid=%b addr=%h pc=%h expected valid=0 addr=00000014 pc=00000014", validF, imem_addr, PCF); end
  endtask

  // Redirect while the request to 0x8 is outstanding: its data must be dropped.
  task automatic test_redirect_outstanding();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hB000_0000 + 32'(i);
      step();
      imem_ack = 1'b0;
      step();
    end
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL drop_pre_addr: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step();
    PCSrcE = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL drop_addr_hold: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
    checks++; if (PCF !== 32'h100 || validF !== 1'b0) begin errors++; $display("FAIL drop_pc: got pc=%h valid=%b expected pc=00000100 valid=0", PCF, validF); end
    step();
    checks++; if (imem_addr !== 32'h8 || validF !== 1'b0) begin errors++; $display("FAIL drop_wait: got addr=%h valid=%b expected addr=00000008 valid=0", imem_addr, validF); end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0008;
    step();
    imem_ack = 1'b0;
    checks++; if (validF !== 1'b0 || instrF !== NOP_W) begin errors++; $display("FAIL drop_discard: got valid=%b instr=%h expected valid=0 instr=%h", validF, instrF, NOP_W); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL drop_refetch: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0100;
    step();
    imem_ack = 1'b0;
    checks++; if (validF !== 1'b1 || instrF !== 32'h0000_0100 || PCF !== 32'h100) begin errors++; $display("FAIL drop_target_instr: got valid=%b instr=%h pc=%h expected valid=1 instr=00000100 pc=00000100", validF, instrF, PCF); end
  endtask

  // Redirect on the same edge as the ack, with StallF=1: ack data is discarded.
  task automatic test_redirect_with_ack();
    do_reset();
    StallF = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    PCSrcE = 1'b0; imem_ack = 1'b0;
    checks++; if (validF !== 1'b0 || instrF !== NOP_W) begin errors++; $display("FAIL same_edge_valid: got valid=%b instr=%h expected valid=0 instr=%h", validF, instrF, NOP_W); end
    checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL same_edge_pc: got %h expected 00000100", PCF); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL same_edge_fetch: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    step();
    checks++; if (validF !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL same_edge_hold: got valid=%b addr=%h expected valid=0 addr=00000100", validF, imem_addr); end
    StallF = 1'b0;
  endtask

  // Unaligned target near the top of memory: aligned PC and wrapping PC+4.
  task automatic test_wrap();
    do_reset();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    step();
    PCSrcE = 1'b0; imem_ack = 1'b0;
    checks++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_pc: got pc=%h pc4=%h expected pc=fffffffc pc4=00000000", PCF, PCPlus4F); end
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr: got %h expected fffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ack = 1'b0;
    checks++; if (validF !== 1'b1 || instrF !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_instr: got valid=%b instr=%h expected valid=1 instr=cafef00d", validF, instrF); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || PCF !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h pc=%h expected req=1 addr=00000000 pc=00000000", imem_req, imem_addr, PCF); end
  endtask

  // Reset asserted asynchronously while a word is held in READY.
  task automatic test_reset_in_ready();
    do_reset();
    StallF = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    checks++; if (validF !== 1'b1 || instrF !== 32'h1234_5678) begin errors++; $display("FAIL rst_ready_pre: got valid=%b instr=%h expected valid=1 instr=12345678", validF, instrF); end
    #2 reset = 1'b1;
    #1;
    checks++; if (instrF !== NOP_W || validF !== 1'b0) begin errors++; $display("FAIL rst_ready_async: got valid=%b instr=%h expected valid=0 instr=%h", validF, instrF, NOP_W); end
    checks++; if (PCF !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_ready_pc: got pc=%h req=%b expected pc=00000000 req=0", PCF, imem_req); end
    step();
    StallF = 1'b0;
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    checks++; if (validF !== 1'b0 || instrF !== NOP_W) begin errors++; $display("FAIL rst_stale_ack: got valid=%b instr=%h expected valid=0 instr=%h", validF, instrF, NOP_W); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_outstanding();
    test_redirect_with_ack();
    test_wrap();
    test_reset_in_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters: RESET_PC, 32'h00000000, PC after reset; NOP, 32'h00000013, bubble presented when no valid instruction.
REQ-002 SHALL have ports, with clock and reset first:
- clk  in  1  clock; rising edge.
- reset  in  1  reset; asynchronous, active-high.
- StallF  in  1  hold current fetch output; same signal as the decode register's EN.
- PCSrcE  in  1  taken branch/jump redirect from execute.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address.
- imem_ack  in  1  read data valid, one pulse per request.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instrF  out  32  instruction to decode register.
- PCF  out  32  PC of instrF.
- PCPlus4F  out  32  PCF+4.
- validF  out  1  instrF holds a real instruction, not a bubble.

Function
REQ-003 SHALL implement states IDLE, FETCH, READY and DROP.
REQ-004 SHALL hold registers PC[31:0], req_addr[31:0], ibuf[31:0] and valid.
REQ-005 IDLE SHALL go to FETCH at the first clock edge after reset is released, loading req_addr<=PC.
REQ-006 In FETCH and DROP, imem_req SHALL be 1; in IDLE and READY it SHALL be 0.
REQ-007 imem_addr SHALL equal req_addr and SHALL stay stable from request start until the ack edge.
REQ-008 FETCH with imem_ack=1 and PCSrcE=0 SHALL load ibuf<=imem_rdata and valid<=1, then go to READY.
REQ-009 READY SHALL be left only on an edge with StallF=0 or PCSrcE=1.
- StallF=0, PCSrcE=0 (instruction consumed): PC<=PC+4, req_addr<=PC+4, valid<=0, go to FETCH.
REQ-010 Outputs SHALL be: instrF = valid ? ibuf : NOP; validF = valid; PCF = PC; PCPlus4F = PC+4, wrapping modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-011 On any edge with PCSrcE=1, PCSrcE SHALL take priority over StallF and ack.
- Always: PC<=PCTargetE with bits [1:0] forced to 00, and valid<=0.
- From READY, or from FETCH with imem_ack=1 in the same cycle: discard imem_rdata, req_addr<=new PC, go to FETCH.
- From FETCH with imem_ack=0: go to DROP; req_addr unchanged.
- From DROP: stay in DROP; PC takes the newest target.
- From IDLE: PC updates; normal IDLE->FETCH transition.
REQ-012 DROP SHALL discard data on imem_ack, then set req_addr<=PC and go to FETCH.
REQ-013 StallF in FETCH or DROP SHALL NOT block acceptance of imem_ack; the instruction is held in READY.
REQ-014 An ack arriving in IDLE or READY is a protocol violation; the block SHALL ignore it.
REQ-015 Each instruction SHALL be presented with validF=1 for at least one cycle.
REQ-016 Each instruction SHALL be consumed exactly once, on the first edge in READY with StallF=0 and PCSrcE=0.
REQ-017 Minimum latency: ack at edge N gives validF=1 after edge N; earliest consume is edge N+1.

Reset
REQ-018 While reset=1, the block SHALL hold: state=IDLE, PC=RESET_PC, req_addr=RESET_PC, ibuf=0, valid=0.
REQ-019 While reset=1, outputs SHALL be: imem_req=0, instrF=NOP, PCF=RESET_PC, PCPlus4F=RESET_PC+4, validF=0.
REQ-020 Reset asserted mid-request SHALL abandon the request immediately; any later stale ack is ignored per REQ-014.

Verification
REQ-021 Reset then 1-cycle-latency memory, StallF=0 -> imem_addr sequence 0x0, 0x4, 0x8; instrF alternates NOP and data; PCF matches each word.
REQ-022 Ack of 0xDEADBEEF at 0x10 with StallF=1 for 3 cycles -> READY held; instrF=0xDEADBEEF, PCF=0x10, PCPlus4F=0x14 stable; imem_req=0; consumed on the first StallF=0 edge.
REQ-023 PCSrcE=1, PCTargetE=0x100 while request to 0x8 is outstanding, ack 2 cycles later -> DROP; 0x8 data never appears with validF=1; next imem_addr=0x100.
REQ-024 PCSrcE=1 in the same cycle as imem_ack (StallF=1) -> data discarded; PC=0x100; FETCH to 0x100; validF=0.
REQ-025 PCTargetE=0xFFFFFFFE -> PC=0xFFFFFFFC, PCPlus4F=0x00000000; after consume, imem_addr=0x00000000.
REQ-026 reset pulsed while in READY with ibuf=0x12345678 -> instrF=NOP, validF=0, PCF=0 during reset; fetch restarts at 0x0.
